uart_rx_os16: RTL and testbench

//  16x-oversampling UART receive front end: 8N1, LSB first, idle high.

---
 rtl/uart_rx_os16_pkg.sv | 27 ++
 rtl/uart_os_tick_gen.sv | 29 ++
 rtl/uart_rx_os16.sv | 142 ++++++++++++++
 tb/tb_uart_rx_os16.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_os16_pkg.sv
// Shared definitions for the 16x oversampling UART receiver: FSM states,
// sample positions within a bit, default tick-generator settings.
package uart_rx_os16_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int unsigned OS   = 16;
   localparam int unsigned TC_W = $clog2(OS);

   localparam logic [TC_W-1:0] SAMPLE_A  = 4'd7;
   localparam logic [TC_W-1:0] SAMPLE_B  = 4'd8;
   localparam logic [TC_W-1:0] SAMPLE_C  = 4'd9;
   localparam logic [TC_W-1:0] LAST_TICK = 4'd15;

   localparam int unsigned ACC_W_DEF = 16;
   localparam int unsigned INC_DEF   = 7550;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Fractional phase accumulator producing the 16x oversample tick;
// tick is the registered carry-out of the accumulator.
module uart_os_tick_gen
   import uart_rx_os16_pkg::*;
#(
   parameter int unsigned ACC_W = ACC_W_DEF,
   parameter int unsigned INC   = INC_DEF
) (
   input  logic clk,
   input  logic nrst,
   output logic tick
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   sum;

   assign sum = {1'b0, acc} + (ACC_W+1)'(INC);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         acc  <= '0;
         tick <= 1'b0;
      end else begin
         acc  <= sum[ACC_W-1:0];
         tick <= sum[ACC_W];
      end
   end

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receive front end: start-glitch filter, 3-sample majority vote,
// framing/break detection and FIFO-write strobe with sticky overrun.
module uart_rx_os16
   import uart_rx_os16_pkg::*;
#(
   parameter int unsigned ACC_W = ACC_W_DEF,
   parameter int unsigned INC   = INC_DEF
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       rx,
   input  logic       fifo_full,
   input  logic       clr_overrun,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       break_det,
   output logic       overrun
);

   logic            tick;
   logic            rx_m, rx_s;
   state_t          state, state_nxt;
   logic [TC_W-1:0] tick_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift;
   logic            armed;
   logic            s_a, s_b;
   logic            vote;

   logic            enter_start, arm_set, bit_clr, shift_en, bit_adv, stop_dec;

   uart_os_tick_gen #(
      .ACC_W (ACC_W),
      .INC   (INC)
   ) u_tick (
      .clk  (clk),
      .nrst (nrst),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // Third sample is the live synchronised value, so the vote is ready at SAMPLE_C.
   assign vote = maj3(s_a, s_b, rx_s);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (tick) begin
         unique case (state)
            IDLE:  if (armed && !rx_s) state_nxt = START;
            START: begin
               if (tick_cnt == SAMPLE_C && vote) state_nxt = IDLE;
               else if (tick_cnt == LAST_TICK)   state_nxt = DATA;
            end
            DATA:  if (tick_cnt == LAST_TICK && bit_cnt == 3'd7) state_nxt = STOP;
            STOP:  if (tick_cnt == SAMPLE_C) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      enter_start = 1'b0;
      arm_set     = 1'b0;
      bit_clr     = 1'b0;
      shift_en    = 1'b0;
      bit_adv     = 1'b0;
      stop_dec    = 1'b0;
      if (tick) begin
         unique case (state)
            IDLE: begin
               enter_start = armed && !rx_s;
               arm_set     = rx_s;
            end
            START: bit_clr = (tick_cnt == LAST_TICK);
            DATA: begin
               shift_en = (tick_cnt == SAMPLE_C);
               bit_adv  = (tick_cnt == LAST_TICK);
            end
            STOP: stop_dec = (tick_cnt == SAMPLE_C);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         armed    <= 1'b0;
         s_a      <= 1'b1;
         s_b      <= 1'b1;
      end else begin
         if (enter_start) tick_cnt <= '0;
         else if (tick)   tick_cnt <= tick_cnt + TC_W'(1);

         if (tick && tick_cnt == SAMPLE_A) s_a <= rx_s;
         if (tick && tick_cnt == SAMPLE_B) s_b <= rx_s;

         if (enter_start)  armed <= 1'b0;
         else if (arm_set) armed <= 1'b1;

         if (bit_clr)      bit_cnt <= '0;
         else if (bit_adv) bit_cnt <= bit_cnt + 3'd1;

         if (shift_en) shift <= {vote, shift[7:1]};
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         break_det <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         valid     <= stop_dec && vote && !fifo_full;
         frame_err <= stop_dec && !vote && (shift != 8'h00);
         break_det <= stop_dec && !vote && (shift == 8'h00);
         if (stop_dec && vote && !fifo_full) data <= shift;
         if (stop_dec && vote && fifo_full) overrun <= 1'b1;
         else if (clr_overrun)              overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: serial frames driven in real time,
// output pulses counted by a monitor and checked with immediate assertions.
`timescale 1ns/1ps
module tb_uart_rx_os16;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       rx = 1'b1;
   logic       fifo_full = 1'b0;
   logic       clr_overrun = 1'b0;
   logic [7:0] data;
   logic       valid, frame_err, break_det, overrun;

   int checks = 0;
   int errors = 0;

   int n_valid = 0, n_fe = 0, n_bd = 0, n_multi = 0, n_ovr = 0;
   logic [7:0] hist [0:63];
   int b_v, b_fe, b_bd, b_ovr;

   localparam real BIT_NOM  = 1389.0;
   localparam real BIT_FAST = 1347.0;
   localparam real BIT_SLOW = 1431.0;

   always #5 clk = ~clk;

   uart_rx_os16 #(.ACC_W(16), .INC(7550)) dut (
      .clk         (clk),
      .nrst        (nrst),
      .rx          (rx),
      .fifo_full   (fifo_full),
      .clr_overrun (clr_overrun),
      .data        (data),
      .valid       (valid),
      .frame_err   (frame_err),
      .break_det   (break_det),
      .overrun     (overrun)
   );

   always @(negedge clk) begin
      if (valid) begin
         hist[n_valid[5:0]] = data;
         n_valid++;
      end
      if (frame_err) n_fe++;
      if (break_det) n_bd++;
      if (overrun)   n_ovr++;
      if ((32'(valid) + 32'(frame_err) + 32'(break_det)) > 1) n_multi++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      b_v = n_valid; b_fe = n_fe; b_bd = n_bd; b_ovr = n_ovr;
   endtask

   task automatic send(input logic [7:0] b, input logic stop_bit, input real bitp);
      rx = 1'b0;
      #(bitp);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(bitp);
      end
      rx = stop_bit;
      #(bitp);
      rx = 1'b1;
   endtask

   initial begin
      // reset state
      #53;
      chk("rst_data",  32'(data), 32'h00);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_fe",    32'(frame_err), 32'h0);
      chk("rst_bd",    32'(break_det), 32'h0);
      chk("rst_ovr",   32'(overrun), 32'h0);
      chk("rst_state", 32'(dut.state), 32'(uart_rx_os16_pkg::IDLE));
      nrst = 1'b1;
      #(2*BIT_NOM);

      // 1: single 0x55
      snap();
      send(8'h55, 1'b1, BIT_NOM);
      #(2*BIT_NOM);
      chk("t1_valid_cnt", 32'(n_valid - b_v), 1);
      chk("t1_data",      32'(data), 32'h55);
      chk("t1_fe_cnt",    32'(n_fe - b_fe), 0);
      chk("t1_bd_cnt",    32'(n_bd - b_bd), 0);

      // 2: back-to-back 0x00, 0xFF
      snap();
      send(8'h00, 1'b1, BIT_NOM);
      send(8'hFF, 1'b1, BIT_NOM);
      #(2*BIT_NOM);
      chk("t2_valid_cnt", 32'(n_valid - b_v), 2);
      chk("t2_first",     32'(hist[b_v[5:0]]), 32'h00);
      chk("t2_second",    32'(hist[6'(b_v + 1)]), 32'hFF);

      // 3: 40-clk start glitch
      snap();
      rx = 1'b0;
      #400;
      rx = 1'b1;
      #(3*BIT_NOM);
      chk("t3_valid_cnt", 32'(n_valid - b_v), 0);
      chk("t3_fe_cnt",    32'(n_fe - b_fe), 0);
      chk("t3_bd_cnt",    32'(n_bd - b_bd), 0);
      chk("t3_state",     32'(dut.state), 32'(uart_rx_os16_pkg::IDLE));

      // 4: 0xA5 with low stop bit
      snap();
      send(8'hA5, 1'b0, BIT_NOM);
      #(2*BIT_NOM);
      chk("t4_fe_cnt",    32'(n_fe - b_fe), 1);
      chk("t4_valid_cnt", 32'(n_valid - b_v), 0);
      chk("t4_bd_cnt",    32'(n_bd - b_bd), 0);
      chk("t4_data_kept", 32'(data), 32'hFF);

      // 5: 20-bit break, then 0x3C
      snap();
      rx = 1'b0;
      #(20*BIT_NOM);
      rx = 1'b1;
      #(2*BIT_NOM);
      chk("t5_bd_cnt", 32'(n_bd - b_bd), 1);
      send(8'h3C, 1'b1, BIT_NOM);
      #(2*BIT_NOM);
      chk("t5_bd_cnt_after", 32'(n_bd - b_bd), 1);
      chk("t5_fe_cnt",       32'(n_fe - b_fe), 0);
      chk("t5_valid_cnt",    32'(n_valid - b_v), 1);
      chk("t5_data",         32'(data), 32'h3C);

      // 6: overrun set, clear, and set-wins-over-clear
      snap();
      fifo_full = 1'b1;
      send(8'h12, 1'b1, BIT_NOM);
      #(2*BIT_NOM);
      chk("t6_valid_cnt", 32'(n_valid - b_v), 0);
      chk("t6_overrun",   32'(overrun), 1);
      chk("t6_data_kept", 32'(data), 32'h3C);
      @(posedge clk); #1 clr_overrun = 1'b1;
      @(posedge clk); #1 clr_overrun = 1'b0;
      chk("t6_cleared", 32'(overrun), 0);
      clr_overrun = 1'b1;
      snap();
      send(8'h12, 1'b1, BIT_NOM);
      #(2*BIT_NOM);
      chk("t6_set_priority_cycles", 32'(n_ovr - b_ovr), 1);
      clr_overrun = 1'b0;
      fifo_full = 1'b0;
      chk("t6_overrun_after_clr", 32'(overrun), 0);

      // 7: reset in the middle of bit 4, then 0xC3
      rx = 1'b0;
      #(BIT_NOM);
      for (int i = 0; i < 4; i++) begin
         rx = (8'hC3 >> i) & 8'h01 ? 1'b1 : 1'b0;
         #(BIT_NOM);
      end
      rx = 1'b0;
      #(BIT_NOM/2);
      nrst = 1'b0;
      #50;
      chk("t7_rst_data",  32'(data), 32'h00);
      chk("t7_rst_valid", 32'(valid), 0);
      chk("t7_rst_state", 32'(dut.state), 32'(uart_rx_os16_pkg::IDLE));
      rx = 1'b1;
      #200;
      nrst = 1'b1;
      #(2*BIT_NOM);
      snap();
      send(8'hC3, 1'b1, BIT_NOM);
      #(2*BIT_NOM);
      chk("t7_valid_cnt", 32'(n_valid - b_v), 1);
      chk("t7_data",      32'(data), 32'hC3);
      chk("t7_fe_cnt",    32'(n_fe - b_fe), 0);

      // 8: +/-3% baud error
      snap();
      send(8'h81, 1'b1, BIT_FAST);
      #(2*BIT_NOM);
      chk("t8_fast_valid", 32'(n_valid - b_v), 1);
      chk("t8_fast_data",  32'(data), 32'h81);
      data_clear_check: begin end
      snap();
      send(8'h7E, 1'b1, BIT_NOM);
      #(2*BIT_NOM);
      snap();
      send(8'h81, 1'b1, BIT_SLOW);
      #(2*BIT_NOM);
      chk("t8_slow_valid", 32'(n_valid - b_v), 1);
      chk("t8_slow_data",  32'(data), 32'h81);
      chk("t8_fe_cnt",     32'(n_fe - b_fe), 0);

      chk("pulse_exclusive", 32'(n_multi), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
